// File: rtl/uart_word_rx.sv
// UART 8N1 receiver producing the memory-mapped status/data word returned for loads from 0x4000.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry byte FIFO.
module uart_word_rx #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_ack,
  output logic [31:0] uart_data,
  output logic        rx_irq
);

  // Must be at least 4 so the half-bit load stays positive.
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic             rx_meta, rx_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             good_q, good_d, bad_q, bad_d;
  logic             ovr_q, ovr_d, fe_q, fe_d;
  logic             valid;
  logic [7:0]       data_out;

  // Synchronizer flops reset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
          state_d = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Registered commit pulses: the word updates one cycle after the mid-stop sample.
          good_d  = rx_s;
          bad_d   = !rx_s;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int FIFO_DEPTH = 4;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q, count_d;
  logic       push, pop, full;

  assign full  = (count_q == 3'd4);
  assign pop   = rd_ack && (count_q != 3'd0);
  assign push  = good_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
    ovr_d = (ovr_q && !rd_ack) || (good_q && full && !pop);
    fe_d  = (fe_q && !rd_ack) || bad_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  assign valid    = (count_q != 3'd0);
  assign data_out = mem_q[rd_ptr_q];
`else
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q && !rd_ack;
    data_d  = data_q;
    ovr_d   = ovr_q && !rd_ack;
    fe_d    = (fe_q && !rd_ack) || bad_q;
    // A still-unread byte is kept; the newcomer only raises overrun.
    if (good_q) begin
      if (valid_d) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      fe_q  <= fe_d;
    end
  end

  assign uart_data = {valid, ovr_q, fe_q, 21'b0, data_out};
  assign rx_irq    = uart_data[31];

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx: directed scenarios plus randomized frames and rd_ack
// pulses, compared every cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_uart_word_rx;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int          CPB    = 10;
  // Start bit driven just after edge k; first sampling edge is k+1, word updates 9.5*CPB+3 later.
  localparam int          COMMIT_DELAY = CPB * 19 / 2 + 4;

`ifdef UART_RX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clk, rst, rx, rd_ack;
  logic [31:0] uart_data;
  logic        rx_irq;

  uart_word_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_ack   (rd_ack),
    .uart_data(uart_data),
    .rx_irq   (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] m_q[$];
  bit         m_valid, m_ovr, m_fe;
  logic [7:0] m_byte;

  // Frame-level model: each sent frame is a scheduled commit event; rd_ack applied per edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        m_byte  = 8'h00;
        pend.delete();
        m_q.delete();
      end else begin
        bit         good, bad, ack, nv, novr, nfe;
        logic [7:0] b;
        edge_n++;
        good = 1'b0;
        bad  = 1'b0;
        b    = 8'h00;
        ack  = rd_ack;
        if (pend.size() > 0 && pend[0].at == edge_n) begin
          good = pend[0].ok;
          bad  = !pend[0].ok;
          b    = pend[0].b;
          pend.delete(0);
        end
        novr = m_ovr && !ack;
        nfe  = (m_fe && !ack) || bad;
        if (FIFO) begin
          if (ack && m_q.size() > 0) m_q.delete(0);
          if (good) begin
            if (m_q.size() < 4) m_q.push_back(b);
            else novr = 1'b1;
          end
          nv = (m_q.size() > 0);
          if (nv) m_byte = m_q[0];
        end else begin
          nv = m_valid && !ack;
          if (good) begin
            if (nv) novr = 1'b1;
            else begin
              m_byte = b;
              nv     = 1'b1;
            end
          end
        end
        m_valid = nv;
        m_ovr   = novr;
        m_fe    = nfe;
      end
    end
  end

  function automatic logic [31:0] word_mask(input bit v);
    // With the FIFO the byte field of an empty queue is not defined.
    return (FIFO && !v) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
  endfunction

  task automatic check_word(input string name, input logic [31:0] exp);
    logic [31:0] m;
    m = word_mask(exp[31]);
    total++;
    if ((((uart_data ^ exp) & m) === 32'h0) && (rx_irq === exp[31])) passed++;
    else $display("FAIL %s: uart_data=%h rx_irq=%b, expected uart_data=%h (mask %h) rx_irq=%b",
                  name, uart_data, rx_irq, exp, m, exp[31]);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) check_word("cycle_model", {m_valid, m_ovr, m_fe, 21'b0, m_byte});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    ev_t ev;
    ev.at = edge_n + COMMIT_DELAY;
    ev.b  = b;
    ev.ok = stop_bit;
    pend.push_back(ev);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic glitch(input int w);
    rx = 1'b0;
    wait_cycles(w);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    wait_cycles(1);
    rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
  endtask

  int  t0, lat;
  bit  done;

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    rd_ack = 1'b0;
    wait_cycles(3);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check_word("reset", 32'h0000_0000);
    wait_cycles(200);
    check_word("idle_200", 32'h0000_0000);

    // 0xA5 with exact latency
    t0  = edge_n;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (rx_irq === 1'b1) begin
            lat = edge_n - t0;
            break;
          end
        end
      end
    join
    check_int("a5_latency", lat, COMMIT_DELAY);
    check_word("a5_word", 32'h8000_00A5);
    pulse_ack();
    check_word("a5_ack", 32'h0000_00A5);

    // overrun with back-to-back frames
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7E, 1'b1);
    check_word("overrun", FIFO ? 32'h8000_003C : 32'hC000_003C);
    pulse_ack();
    check_word("overrun_ack1", FIFO ? 32'h8000_007E : 32'h0000_003C);
    pulse_ack();
    check_word("overrun_ack2", FIFO ? 32'h0000_007E : 32'h0000_003C);

    // framing error
    do_reset();
    send_frame(8'h55, 1'b0);
    check_word("frame_err", 32'h2000_0000);
    wait_cycles(2 * CPB);
    check_word("frame_err_hold", 32'h2000_0000);
    pulse_ack();
    check_word("frame_err_ack", 32'h0000_0000);

    // short low glitch, then a real frame
    glitch(3);
    wait_cycles(3 * CPB);
    check_word("glitch", 32'h0000_0000);
    send_frame(8'h01, 1'b1);
    check_word("after_glitch", 32'h8000_0001);

    // reset in the middle of frame 0xFF
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(3 * CPB);
    rst = 1'b1;
    #1;
    check_word("rst_mid_frame", 32'h0000_0000);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2 * CPB);
    check_word("rst_released", 32'h0000_0000);
    send_frame(8'h12, 1'b1);
    check_word("after_rst", 32'h8000_0012);

    // randomized frames, glitches and rd_ack pulses
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          int unsigned kind;
          bit          ok;
          kind = $urandom_range(0, 9);
          if (kind == 0) begin
            glitch(int'($urandom_range(1, 4)));
            wait_cycles(2 * CPB);
          end else begin
            ok = (kind != 1);
            send_frame(8'($urandom_range(0, 255)), ok);
            if (ok) wait_cycles(int'($urandom_range(0, 12)));
            else wait_cycles(2 * CPB + int'($urandom_range(0, 5)));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          if ($urandom_range(0, 7) == 0) rd_ack = 1'b1;
          wait_cycles(1);
          rd_ack = 1'b0;
        end
      end
    join
    wait_cycles(2 * CPB);
    pulse_ack();
    check_word("final_ack_flags", {3'b000, 21'b0, m_byte});
    wait_cycles(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
